keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 177 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with press/release
// debounce and a single key_valid pulse per accepted key.
//
// Ports:
//   clock      system clock, rising-edge active
//   reset_n    synchronous active-low reset
//   keyboard   row lines, active-low (4'b1111 = nothing in driven column)
//   hex_in     key code from the external row/column encoder
//   counter    column index handed to the encoder
//   col_n      active-low column drive, ~(4'b0001 << counter)
//   key_valid  one-cycle pulse for a newly accepted key
//   key_code   code latched on acceptance, held until the next one
//   key_down   high from acceptance until the release is debounced

module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] keyboard,
    input  logic [3:0] hex_in,
    output logic [1:0] counter,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down
);

    // Dwell counts 0..SCAN_DIV-1; debounce counts 0..DEBOUNCE_CNT-1 and
    // the final match transitions instead of storing DEBOUNCE_CNT.
    localparam int DW  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DBW = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;

    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CNT - 1);

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        HOLD,
        RELEASE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     counter_nxt;
    logic [DW-1:0]  dwell;
    logic [DW-1:0]  dwell_nxt;
    logic [DBW-1:0] deb;
    logic [DBW-1:0] deb_nxt;
    logic [3:0]     pattern;
    logic [3:0]     pattern_nxt;
    logic [3:0]     code_nxt;
    logic           valid_nxt;
    logic           down_nxt;

    logic [3:0]     low_rows;
    logic           one_low;
    logic           all_high;
    logic           dwell_end;

    // Exactly one row pulled low means a single unambiguous key.
    assign low_rows  = ~keyboard;
    assign one_low   = (low_rows != 4'd0) &&
                       ((low_rows & (low_rows - 4'd1)) == 4'd0);
    assign all_high  = (keyboard == 4'b1111);
    assign dwell_end = (dwell == DWELL_LAST);

    assign col_n = ~(4'b0001 << counter);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= SCAN;
            counter   <= 2'd0;
            dwell     <= '0;
            deb       <= '0;
            pattern   <= 4'b1111;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_nxt;
            counter   <= counter_nxt;
            dwell     <= dwell_nxt;
            deb       <= deb_nxt;
            pattern   <= pattern_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_down  <= down_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        dwell_nxt   = dwell;
        deb_nxt     = deb;
        pattern_nxt = pattern;
        code_nxt    = key_code;
        valid_nxt   = 1'b0;
        down_nxt    = key_down;

        unique case (state)
            SCAN: begin
                if (dwell_end) begin
                    dwell_nxt = '0;
                    if (one_low) begin
                        // Freeze the column and watch this row pattern.
                        pattern_nxt = keyboard;
                        deb_nxt     = '0;
                        state_nxt   = DEBOUNCE;
                    end else begin
                        counter_nxt = counter + 2'd1;
                    end
                end else begin
                    dwell_nxt = dwell + DW'(1);
                end
            end

            DEBOUNCE: begin
                if (keyboard == pattern) begin
                    if (deb == DEB_LAST) begin
                        deb_nxt   = '0;
                        state_nxt = PRESSED;
                    end else begin
                        deb_nxt = deb + DBW'(1);
                    end
                end else begin
                    // Bounce: give up on this column, move on.
                    deb_nxt     = '0;
                    dwell_nxt   = '0;
                    counter_nxt = counter + 2'd1;
                    state_nxt   = SCAN;
                end
            end

            PRESSED: begin
                code_nxt  = hex_in;
                valid_nxt = 1'b1;
                down_nxt  = 1'b1;
                state_nxt = HOLD;
            end

            HOLD: begin
                // Only a full release matters; extra keys are ignored.
                if (all_high) begin
                    deb_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end

            RELEASE: begin
                if (all_high) begin
                    if (deb == DEB_LAST) begin
                        deb_nxt     = '0;
                        down_nxt    = 1'b0;
                        dwell_nxt   = '0;
                        counter_nxt = counter + 2'd1;
                        state_nxt   = SCAN;
                    end else begin
                        deb_nxt = deb + DBW'(1);
                    end
                end else begin
                    deb_nxt   = '0;
                    state_nxt = HOLD;
                end
            end

            default: begin
                state_nxt = SCAN;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner
// with SCAN_DIV=4 and DEBOUNCE_CNT=3.

module tb_keypad_scanner;

    logic       clock;
    logic       reset_n;
    logic [3:0] keyboard;
    logic [3:0] hex_in;
    logic [1:0] counter;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_down;

    int total;
    int fails;

    keypad_scanner #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(3)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .keyboard (keyboard),
        .hex_in   (hex_in),
        .counter  (counter),
        .col_n    (col_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_down (key_down)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_col(input string tag, input logic [1:0] exp_cnt);
        logic [3:0] exp_col;
        exp_col = ~(4'b0001 << exp_cnt);
        check({tag, "_counter"}, {6'd0, counter}, {6'd0, exp_cnt});
        check({tag, "_col_n"}, {4'd0, col_n}, {4'd0, exp_col});
    endtask

    task automatic check_reset(input string tag);
        check_col(tag, 2'd0);
        check({tag, "_valid"}, {7'd0, key_valid}, 8'd0);
        check({tag, "_code"}, {4'd0, key_code}, 8'd0);
        check({tag, "_down"}, {7'd0, key_down}, 8'd0);
    endtask

    initial begin
        total    = 0;
        fails    = 0;
        reset_n  = 1'b0;
        keyboard = 4'b1111;
        hex_in   = 4'h0;

        // Reset
        step();
        check_reset("reset");
        reset_n = 1'b1;

        // Idle scan: each column dwells 4 observations
        for (int k = 1; k <= 20; k++) begin
            step();
            check_col($sformatf("idle%0d", k), 2'((k / 4) % 4));
            check($sformatf("idle%0d_valid", k), {7'd0, key_valid}, 8'd0);
        end
        // Now at counter 1, dwell 0

        // Clean press on column 1
        repeat (3) step();
        keyboard = 4'b1101;
        hex_in   = 4'h6;
        step();
        check_col("press_sample", 2'd1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("press_wait%0d_valid", k),
                  {7'd0, key_valid}, 8'd0);
            check_col($sformatf("press_wait%0d", k), 2'd1);
        end
        step();
        check("press_pulse", {7'd0, key_valid}, 8'd1);
        check("press_code", {4'd0, key_code}, 8'h06);
        check("press_down", {7'd0, key_down}, 8'd1);
        hex_in = 4'h0;
        step();
        check("press_pulse_end", {7'd0, key_valid}, 8'd0);
        check("hold_down", {7'd0, key_down}, 8'd1);
        check_col("hold", 2'd1);

        // Extra key in HOLD is ignored
        keyboard = 4'b1001;
        step();
        check("hold_multi_valid", {7'd0, key_valid}, 8'd0);
        check("hold_multi_down", {7'd0, key_down}, 8'd1);

        // One-cycle release glitch
        keyboard = 4'b1111;
        step();
        keyboard = 4'b1101;
        step();
        check("glitch_down", {7'd0, key_down}, 8'd1);
        check("glitch_valid", {7'd0, key_valid}, 8'd0);
        repeat (3) begin
            step();
            check("glitch_nopulse", {7'd0, key_valid}, 8'd0);
        end
        check_col("glitch", 2'd1);

        // Release: HOLD sees 1111, then 3 debounced cycles
        keyboard = 4'b1111;
        step();
        check("rel_enter_down", {7'd0, key_down}, 8'd1);
        step();
        step();
        check("rel_2_down", {7'd0, key_down}, 8'd1);
        check_col("rel_2", 2'd1);
        step();
        check("rel_done_down", {7'd0, key_down}, 8'd0);
        check("rel_done_valid", {7'd0, key_valid}, 8'd0);
        check("rel_code_held", {4'd0, key_code}, 8'h06);
        check_col("rel_done", 2'd2);

        // Bounce on column 2
        repeat (3) step();
        keyboard = 4'b1101;
        hex_in   = 4'h9;
        step();
        check_col("bounce_sample", 2'd2);
        step();
        keyboard = 4'b1111;
        step();
        check_col("bounce_abort", 2'd3);
        check("bounce_valid", {7'd0, key_valid}, 8'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("bounce_after%0d_valid", k),
                  {7'd0, key_valid}, 8'd0);
            check_col($sformatf("bounce_after%0d", k), 2'd3);
        end
        // Multi-key at column 3 dwell end: ignored
        keyboard = 4'b1001;
        step();
        check_col("multi", 2'd0);
        check("multi_valid", {7'd0, key_valid}, 8'd0);
        check("multi_down", {7'd0, key_down}, 8'd0);
        keyboard = 4'b1111;

        // Second press on column 0, then reset mid-HOLD
        repeat (3) step();
        keyboard = 4'b1110;
        hex_in   = 4'hA;
        step();
        repeat (3) step();
        check("p2_wait_valid", {7'd0, key_valid}, 8'd0);
        step();
        check("p2_pulse", {7'd0, key_valid}, 8'd1);
        check("p2_code", {4'd0, key_code}, 8'h0A);
        step();
        check("p2_hold_down", {7'd0, key_down}, 8'd1);
        check_col("p2_hold", 2'd0);
        reset_n = 1'b0;
        step();
        check_reset("rst_hold");
        reset_n  = 1'b1;
        keyboard = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_col($sformatf("restart%0d", k), 2'(k / 4));
            check($sformatf("restart%0d_down", k), {7'd0, key_down}, 8'd0);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
